// File: rtl/wm_pixel_fetch.sv
// Pixel/neighbour/watermark-symbol feeder for the watermark insertion stage.
// Optional build macro WM_EMBED_BORDER_EN: row 0 and column 0 also consume symbols.
module wm_pixel_fetch #(
  parameter int IMG_W  = 256,
  parameter int IMG_H  = 256,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] pix_in,
  input  logic              pix_valid,
  output logic              pix_ready,
  input  logic [7:0]        wm_byte,
  input  logic              wm_valid,
  output logic              wm_ready,
  output logic [DATA_W-1:0] Data1,
  output logic [DATA_W-1:0] Data2,
  output logic [DATA_W-1:0] Data3,
  output logic [DATA_W-1:0] Data4,
  output logic [1:0]        WM_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  // Symbol 11 is reserved and goes out as "no watermark".
  function automatic logic [1:0] sym_clean(input logic [1:0] s);
    return (s == 2'b11) ? 2'b00 : s;
  endfunction

  state_t            state;
  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic [DATA_W-1:0] line_buf [IMG_W];
  logic [DATA_W-1:0] left_p0;
  logic [DATA_W-1:0] upleft_p0;
  logic [7:0]        sym_reg;
  logic [1:0]        sym_idx;
  logic              sym_full;
  logic              tail;

  logic [DATA_W-1:0] d1_p1, d2_p1, d3_p1, d4_p1;
  logic [1:0]        wm_p1;
  logic              vld_p1;
  logic              busy_r, done_r;

  logic              col_first, row_first, eligible, last_pix;
  logic              accept, consume, wm_load, pix_ready_c, wm_ready_c;
  logic [DATA_W-1:0] up_raw, n_d2, n_d3, n_d4;
  logic [1:0]        sym_sel, n_wm;

  // Stage p0: handshakes, neighbour selection with edge replication
  assign col_first = (col == '0);
  assign row_first = (row == '0);
  assign last_pix  = (col == COL_LAST) && (row == ROW_LAST);
`ifdef WM_EMBED_BORDER_EN
  assign eligible  = 1'b1;
`else
  assign eligible  = !col_first && !row_first;
`endif

  // tail blocks pixels of a following frame until the last bundle drains.
  assign pix_ready_c = (state == S_RUN) && !tail && (!vld_p1 || out_ready) &&
                       (!eligible || sym_full);
  assign wm_ready_c  = (state == S_RUN) && !sym_full;
  assign accept      = pix_valid && pix_ready_c;
  assign consume     = accept && eligible;
  assign wm_load     = wm_valid && wm_ready_c;

  assign up_raw  = line_buf[col];
  assign n_d2    = col_first ? pix_in : left_p0;
  assign n_d3    = row_first ? pix_in : up_raw;
  assign n_d4    = row_first ? n_d2 : (col_first ? up_raw : upleft_p0);
  assign sym_sel = sym_reg[{sym_idx, 1'b0} +: 2];
  assign n_wm    = eligible ? sym_clean(sym_sel) : 2'b00;

  always_ff @(posedge clk) begin
    if (accept) begin
      line_buf[col] <= pix_in;
      left_p0       <= pix_in;
      upleft_p0     <= up_raw;
    end
    if (wm_load) sym_reg <= wm_byte;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      col      <= '0;
      row      <= '0;
      sym_idx  <= '0;
      sym_full <= 1'b0;
      tail     <= 1'b0;
      vld_p1   <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      d1_p1    <= '0;
      d2_p1    <= '0;
      d3_p1    <= '0;
      d4_p1    <= '0;
      wm_p1    <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          state  <= S_RUN;
          busy_r <= 1'b1;
          col    <= '0;
          row    <= '0;
          tail   <= 1'b0;
        end
        S_RUN: if (vld_p1 && out_ready && tail) begin
          state  <= S_DONE;
          done_r <= 1'b1;
        end
        S_DONE: begin
          state    <= S_IDLE;
          busy_r   <= 1'b0;
          sym_full <= 1'b0;
          tail     <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase

      if (accept) begin
        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
        if (last_pix) tail <= 1'b1;
      end

      if (wm_load) begin
        sym_idx  <= '0;
        sym_full <= 1'b1;
      end else if (consume) begin
        sym_idx <= sym_idx + 2'd1;
        if (sym_idx == 2'd3) sym_full <= 1'b0;
      end

      // Stage p1: registered bundle, held while the consumer stalls
      if (accept) begin
        vld_p1 <= 1'b1;
        d1_p1  <= pix_in;
        d2_p1  <= n_d2;
        d3_p1  <= n_d3;
        d4_p1  <= n_d4;
        wm_p1  <= n_wm;
      end else if (out_ready) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign pix_ready = pix_ready_c;
  assign wm_ready  = wm_ready_c;
  assign Data1     = d1_p1;
  assign Data2     = d2_p1;
  assign Data3     = d3_p1;
  assign Data4     = d4_p1;
  assign WM_data   = wm_p1;
  assign out_valid = vld_p1;
  assign busy      = busy_r;
  assign done      = done_r;

endmodule

// File: tb/tb_wm_pixel_fetch.sv
// Table-driven bench for wm_pixel_fetch on a 4x3 frame of pixels 0..11.
module tb_wm_pixel_fetch;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int NP = W * H;

  logic       clk = 1'b0;
  logic       rst = 1'b1, start = 1'b0, pix_valid = 1'b0, wm_valid = 1'b0, out_ready = 1'b0;
  logic [7:0] pix_in = '0, wm_byte = '0;
  logic       pix_ready, wm_ready, out_valid, busy, done;
  logic [7:0] Data1, Data2, Data3, Data4;
  logic [1:0] WM_data;

  wm_pixel_fetch #(.IMG_W(W), .IMG_H(H), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .start(start),
    .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .wm_byte(wm_byte), .wm_valid(wm_valid), .wm_ready(wm_ready),
    .Data1(Data1), .Data2(Data2), .Data3(Data3), .Data4(Data4),
    .WM_data(WM_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] pix;
    logic [7:0] d1, d2, d3, d4;
    logic [1:0] wm;
  } vec_t;

  vec_t        tbl [NP];
  int          wm_exp [NP];
  logic [33:0] got [NP];
  logic [7:0]  wm_q [4];
  int ngot, nextra, nbytes, wptr, pptr, ndone, ptr_at_b2;
  int n_cmp = 0, n_bad = 0;
  bit want_start = 0, want_rst = 0, ordy = 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // One clock: drive at negedge, observe handshakes just after, edge follows.
  task automatic step();
    @(negedge clk);
    rst        = want_rst;
    start      = want_start;
    want_start = 0;
    want_rst   = 0;
    out_ready  = ordy;
    pix_valid  = (pptr < NP);
    pix_in     = (pptr < NP) ? tbl[pptr].pix : 8'd0;
    wm_valid   = (wptr < nbytes);
    wm_byte    = (wptr < nbytes) ? wm_q[wptr] : 8'd0;
    #1;
    if (out_valid && out_ready) begin
      if (ngot < NP) begin
        got[ngot] = {Data1, Data2, Data3, Data4, WM_data};
        ngot++;
      end else nextra++;
    end
    if (wm_valid && wm_ready) begin
      wptr++;
      if (wptr == 2) ptr_at_b2 = pptr;
    end
    if (pix_valid && pix_ready) pptr++;
    if (done) ndone++;
  endtask

  task automatic clear_counts();
    ngot = 0; nextra = 0; pptr = 0; wptr = 0; ndone = 0; ptr_at_b2 = -1;
  endtask

  task automatic run_frame(input string tag, input int stall_from, input int stall_len,
                           input bit wm_zero);
    logic [33:0] snap, req;
    int fc;
    clear_counts();
    snap = '0;
    ordy = 1;
    want_start = 1;
    step();
    fc = 0;
    while (ndone == 0 && fc < 300) begin
      ordy = !(fc >= stall_from && fc < stall_from + stall_len);
      step();
      if (fc == 2) chk({tag, " busy_mid"}, busy, 1);
      if (!ordy) begin
        chk($sformatf("%s stall_pix_ready c%0d", tag, fc), pix_ready, 0);
        if (fc > stall_from)
          chk($sformatf("%s stall_hold c%0d", tag, fc),
              {Data1, Data2, Data3, Data4, WM_data, out_valid}, {snap, 1'b1});
        snap = {Data1, Data2, Data3, Data4, WM_data};
      end
      fc++;
    end
    if (ndone == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s done_timeout: got no done required done within 300 cycles", tag);
    end
    ordy = 1;
    repeat (3) step();
    chk({tag, " done_pulses"}, ndone, 1);
    chk({tag, " busy_end"}, busy, 0);
    chk({tag, " bundles"}, ngot, NP);
    chk({tag, " extra_bundles"}, nextra, 0);
    for (int i = 0; i < ngot; i++) begin
      req = {tbl[i].d1, tbl[i].d2, tbl[i].d3, tbl[i].d4, wm_zero ? 2'b00 : tbl[i].wm};
      chk($sformatf("%s pix%0d", tag, i), got[i], req);
    end
  endtask

  task automatic load_normal_bytes();
    wm_q[0] = 8'h24; wm_q[1] = 8'h39; wm_q[2] = 8'h24; wm_q[3] = 8'h00;
    nbytes = 3;
  endtask

  initial begin
    // {pix, D1, D2, D3, D4} for the 4x3 raster 0..11
    tbl[0]  = '{8'd0,  8'd0,  8'd0,  8'd0, 8'd0, 2'd0};
    tbl[1]  = '{8'd1,  8'd1,  8'd0,  8'd1, 8'd0, 2'd0};
    tbl[2]  = '{8'd2,  8'd2,  8'd1,  8'd2, 8'd1, 2'd0};
    tbl[3]  = '{8'd3,  8'd3,  8'd2,  8'd3, 8'd2, 2'd0};
    tbl[4]  = '{8'd4,  8'd4,  8'd4,  8'd0, 8'd0, 2'd0};
    tbl[5]  = '{8'd5,  8'd5,  8'd4,  8'd1, 8'd0, 2'd0};
    tbl[6]  = '{8'd6,  8'd6,  8'd5,  8'd2, 8'd1, 2'd0};
    tbl[7]  = '{8'd7,  8'd7,  8'd6,  8'd3, 8'd2, 2'd0};
    tbl[8]  = '{8'd8,  8'd8,  8'd8,  8'd4, 8'd4, 2'd0};
    tbl[9]  = '{8'd9,  8'd9,  8'd8,  8'd5, 8'd4, 2'd0};
    tbl[10] = '{8'd10, 8'd10, 8'd9,  8'd6, 8'd5, 2'd0};
    tbl[11] = '{8'd11, 8'd11, 8'd10, 8'd7, 8'd6, 2'd0};
    // Bytes 0x24, 0x39, 0x24 -> symbols 0,1,2,0 | 1,2,(3->0),0 | 0,1,2,0
`ifdef WM_EMBED_BORDER_EN
    wm_exp = '{0, 1, 2, 0, 1, 2, 0, 0, 0, 1, 2, 0};
`else
    wm_exp = '{0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 1, 2};
`endif
    for (int i = 0; i < NP; i++) tbl[i].wm = 2'(wm_exp[i]);

    clear_counts();
    nbytes = 0;
    repeat (3) begin want_rst = 1; step(); end
    @(negedge clk);
    rst = 0;
    #1;
    chk("rst_data", {Data1, Data2, Data3, Data4, WM_data}, 34'd0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_pix_ready", pix_ready, 0);
    chk("rst_wm_ready", wm_ready, 0);
    chk("rst_busy_done", {busy, done}, 2'b00);

    load_normal_bytes();
    run_frame("frame1", 0, 0, 1'b0);

    wm_q[0] = 8'hFF; wm_q[1] = 8'hFF; wm_q[2] = 8'hFF; wm_q[3] = 8'hFF;
    nbytes = 4;
    run_frame("ff", 0, 0, 1'b1);
`ifdef WM_EMBED_BORDER_EN
    chk("ff bytes_taken", wptr, 4);
    chk("ff pix_before_byte2", ptr_at_b2, 4);
`else
    chk("ff bytes_taken", wptr, 2);
    chk("ff pix_before_byte2", ptr_at_b2, 10);
`endif

    load_normal_bytes();
    run_frame("stall", 4, 5, 1'b0);

    load_normal_bytes();
    clear_counts();
    ordy = 1;
    want_start = 1;
    step();
    for (int k = 0; k < 100 && pptr < 7; k++) step();
    chk("midrst reached_pix7", pptr, 7);
    want_rst = 1;
    step();
    @(negedge clk);
    rst = 0;
    #1;
    chk("midrst data", {Data1, Data2, Data3, Data4, WM_data}, 34'd0);
    chk("midrst ctrl", {out_valid, pix_ready, wm_ready, busy, done}, 5'b00000);
    run_frame("after_rst", 0, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wm_pixel_fetch.md
# wm_pixel_fetch

Upstream feeder for the watermark insertion stage. It accepts a raster-order 8-bit grayscale pixel stream and a byte stream of packed watermark symbols. For every pixel it emits a registered bundle to the insertion stage: the current pixel, its left, upper and upper-left neighbours, and one 2-bit ternary watermark symbol. A one-row line buffer holds the previous row, and a frame FSM runs one frame per `start` and pulses `done` when the frame finishes.

## Interface
- `IMG_W`, 256, pixels per row (≥2)
- `IMG_H`, 256, rows per frame (≥2)
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  single-cycle frame start; ignored unless IDLE
- `pix_in`  in  8  incoming pixel, raster order
- `pix_valid`  in  1  `pix_in` valid
- `pix_ready`  out  1  pixel accepted when `pix_valid & pix_ready`
- `wm_byte`  in  8  four packed symbols; bits [1:0] are used first
- `wm_valid`  in  1  `wm_byte` valid
- `wm_ready`  out  1  byte accepted when `wm_valid & wm_ready`
- `Data1`  out  8  current pixel P(r,c)
- `Data2`  out  8  left neighbour P(r,c-1)
- `Data3`  out  8  upper neighbour P(r-1,c)
- `Data4`  out  8  upper-left neighbour P(r-1,c-1)
- `WM_data`  out  2  symbol: 00 = none, 01 = type A, 10 = type B
- `out_valid`  out  1  bundle valid
- `out_ready`  in  1  bundle consumed when `out_valid & out_ready`
- `busy`  out  1  high outside IDLE
- `done`  out  1  one-cycle pulse at frame end

## Operation
- States: IDLE, RUN, DONE.
  - IDLE → RUN on `start`.
  - RUN → DONE when the bundle for pixel (IMG_H-1, IMG_W-1) is consumed.
  - DONE → IDLE after exactly one cycle; `done` = 1 in DONE only.
- Counters `col` (0..IMG_W-1) and `row` (0..IMG_H-1) advance on each accepted pixel. `col` wraps to 0 and `row` increments.
- Line buffer: IMG_W × 8 bits, indexed by `col`. On acceptance at `col`, the old entry becomes the upper neighbour, then the current pixel is written (read-before-write, same cycle).
- Registers `left` and `upleft` capture the current pixel and the upper value on each acceptance.
- Edge replication:
  - c = 0: Data2 = Data1 and Data4 = Data3.
  - r = 0: Data3 = Data1 and Data4 = Data2.
  - (0,0): all four outputs equal P(0,0).
- Eligible pixel: r ≥ 1 and c ≥ 1 (see Configuration).
  - An eligible pixel consumes the next symbol; a non-eligible pixel gets WM_data = 00 and consumes nothing.
- Symbol unpack:
  - `sym_reg` (8 bits), `sym_idx` (2 bits), `sym_full` flag.
  - `wm_ready` = RUN & !`sym_full`.
  - A byte load sets `sym_full` and `sym_idx` = 0.
  - Each consumption increments `sym_idx`; consuming at `sym_idx` = 3 clears `sym_full`.
  - Symbol 11 is emitted as 00 but still counts as consumed.
- `pix_ready` = RUN & (!`out_valid` | `out_ready`) & (!eligible | `sym_full`).
- Symbols left unconsumed at frame end are discarded: `sym_full` is cleared in DONE.
- `start` in RUN or DONE is ignored.

## Timing
- Latency: pixel accepted at edge N → bundle on the outputs with `out_valid` = 1 after edge N.
- Full throughput: 1 pixel/cycle when `out_ready` = 1 and symbols are available. Refilling the symbol byte costs 1 bubble on an eligible pixel.
- The bundle holds stable while `out_valid & !out_ready`.
- `out_valid` clears on consumption unless a new pixel is accepted in the same cycle.
- Reset values: state IDLE; `pix_ready`, `wm_ready`, `out_valid`, `busy` and `done` all 0; Data1–Data4 = 0; WM_data = 00.
- `rst` mid-frame: everything above is restored on the next edge, counters and `sym_full` are cleared, and line buffer contents are don't-care.

## Configuration
- `WM_EMBED_BORDER_EN`
  - Defined: every pixel is eligible, so row 0 and column 0 also consume symbols.
  - Undefined: only r ≥ 1, c ≥ 1 are eligible.
  - Edge replication of neighbours is identical in both builds.

## Test plan
- IMG_W=4, IMG_H=3, pixels 0..11, wm_byte 0x24 (symbols 00,01,10,00), `out_ready` = 1:
  - pixel 5 → D1=5, D2=4, D3=1, D4=0, WM=00.
  - pixel 6 → WM=01.
  - pixel 7 → WM=10.
  - `done` pulses once after pixel 11.
- Same frame, pixel 0 → D1..D4 all 0. Pixel 4 (c=0) → D2=4, D3=0, D4=0.
- wm_byte 0xFF → every eligible pixel gets WM=00. A second byte is requested only after 4 eligible pixels.
- `out_ready` held 0 for 5 cycles → `pix_ready` = 0 and bundle stable. Release → no pixel lost or duplicated across 12 outputs.
- `rst` at pixel 7 → next cycle state IDLE and all outputs 0. A new `start` produces a correct full frame.
- Build with `WM_EMBED_BORDER_EN`, wm_byte 0x24 → pixel 0 gets WM=00, pixel 1 gets WM=01, pixel 2 gets WM=10.
